level_sequencer: RTL and testbench

Game-phase controller that sequences the target-score screen, the timed mining round and the level pass/fail decision. It owns the current level, drives `display_target` for the target screen and compares the player score against the level target at round end. It sits between the keyboard/start logic, the VGA frame-start pulse and the renderers: target screen, HUD timer and play-field enable.

---
 rtl/gold_miner_pkg.sv | 21 ++
 rtl/round_timer.sv | 53 +++++
 rtl/level_sequencer.sv | 138 +++++++++++++
 tb/tb_level_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gold_miner_pkg.sv
// Shared phase encoding and level-target arithmetic for the gold-miner game controller.
package gold_miner_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TARGET,
    S_PLAY,
    S_CHECK,
    S_LOSE,
    S_WIN
  } phase_t;

  localparam int unsigned TARGET_SCORE_MULT = 80;

  function automatic int unsigned target_for_level(input logic [3:0] lvl);
    int unsigned l;
    l = 32'(lvl);
    return TARGET_SCORE_MULT * l * l;
  endfunction

endpackage

// File: rtl/round_timer.sv
// Round countdown: divides frame pulses into seconds and counts time_left down to zero.
module round_timer #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       frame_start,
  input  logic       enable,
  output logic [6:0] time_left,
  output logic       expired
);

  localparam int unsigned SUB_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [6:0]       time_left_q, time_left_d;

  // expired is combinational so the parent FSM leaves PLAY on the same edge as the 1->0 step
  always_comb begin
    sub_cnt_d   = sub_cnt_q;
    time_left_d = time_left_q;
    expired     = 1'b0;
    if (load) begin
      sub_cnt_d   = '0;
      time_left_d = 7'(ROUND_SECONDS);
    end else if (enable && frame_start) begin
      if (sub_cnt_q == SUB_W'(FRAMES_PER_SEC - 1)) begin
        sub_cnt_d = '0;
        if (time_left_q != '0) begin
          time_left_d = time_left_q - 7'd1;
          expired     = (time_left_q == 7'd1);
        end
      end else begin
        sub_cnt_d = sub_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_cnt_q   <= '0;
      time_left_q <= '0;
    end else begin
      sub_cnt_q   <= sub_cnt_d;
      time_left_q <= time_left_d;
    end
  end

  assign time_left = time_left_q;

endmodule

// File: rtl/level_sequencer.sv
// Game-phase controller: target screen, timed round, pass/fail and level advance.
// Optional LEVEL_SEQ_EARLY_EXIT_EN ends the round as soon as the target score is met.
module level_sequencer
  import gold_miner_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned TARGET_FRAMES  = 120,
  parameter int unsigned ROUND_SECONDS  = 60,
  parameter int unsigned MAX_LEVEL      = 10,
  parameter int unsigned SCORE_W        = 20
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_start,
  input  logic [SCORE_W-1:0] player_score,
  output logic               display_target,
  output logic               play_en,
  output logic [3:0]         level,
  output logic [SCORE_W-1:0] target_score,
  output logic [6:0]         time_left,
  output logic               level_up,
  output logic               game_over,
  output logic               game_win
);

  localparam int unsigned FC_W = (TARGET_FRAMES > 1) ? $clog2(TARGET_FRAMES) : 1;

  phase_t             state_q, state_d;
  logic [3:0]         level_q, level_d;
  logic [SCORE_W-1:0] target_q, target_d;
  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic               level_up_q, level_up_d;
  logic               display_target_q, display_target_d;
  logic               play_en_q, play_en_d;
  logic               game_over_q, game_over_d;
  logic               game_win_q, game_win_d;
  logic               score_met, early_stop, timer_load, timer_en, timer_expired;

  assign score_met  = (player_score >= target_q);
`ifdef LEVEL_SEQ_EARLY_EXIT_EN
  assign early_stop = (state_q == S_PLAY) && score_met;
`else
  assign early_stop = 1'b0;
`endif
  assign timer_load = (state_q == S_TARGET) && frame_start &&
                      (frame_cnt_q == FC_W'(TARGET_FRAMES - 1));
  assign timer_en   = (state_q == S_PLAY) && !early_stop;

  round_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .ROUND_SECONDS (ROUND_SECONDS)
  ) u_round_timer (
    .clk        (Clk),
    .rst_n      (reset),
    .load       (timer_load),
    .frame_start(frame_start),
    .enable     (timer_en),
    .time_left  (time_left),
    .expired    (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    target_d    = target_q;
    frame_cnt_d = frame_cnt_q;
    level_up_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_LOSE, S_WIN: begin
        if (start) begin
          state_d     = S_TARGET;
          level_d     = 4'd1;
          target_d    = SCORE_W'(target_for_level(4'd1));
          frame_cnt_d = '0;
        end
      end
      S_TARGET: begin
        if (timer_load)       state_d     = S_PLAY;
        else if (frame_start) frame_cnt_d = frame_cnt_q + 1'b1;
      end
      S_PLAY: begin
        if (early_stop || timer_expired) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!score_met) begin
          state_d = S_LOSE;
        end else if (level_q < 4'(MAX_LEVEL)) begin
          state_d     = S_TARGET;
          level_d     = level_q + 4'd1;
          target_d    = SCORE_W'(target_for_level(level_q + 4'd1));
          level_up_d  = 1'b1;
          frame_cnt_d = '0;
        end else begin
          state_d = S_WIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    display_target_d = (state_d == S_TARGET);
    play_en_d        = (state_d == S_PLAY);
    game_over_d      = (state_d == S_LOSE);
    game_win_d       = (state_d == S_WIN);
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      level_q          <= '0;
      target_q         <= '0;
      frame_cnt_q      <= '0;
      level_up_q       <= 1'b0;
      display_target_q <= 1'b0;
      play_en_q        <= 1'b0;
      game_over_q      <= 1'b0;
      game_win_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      level_q          <= level_d;
      target_q         <= target_d;
      frame_cnt_q      <= frame_cnt_d;
      level_up_q       <= level_up_d;
      display_target_q <= display_target_d;
      play_en_q        <= play_en_d;
      game_over_q      <= game_over_d;
      game_win_q       <= game_win_d;
    end
  end

  assign display_target = display_target_q;
  assign play_en        = play_en_q;
  assign level          = level_q;
  assign target_score   = target_q;
  assign level_up       = level_up_q;
  assign game_over      = game_over_q;
  assign game_win       = game_win_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed self-checking bench for level_sequencer with default parameters.
module tb_level_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        frame_start;
  logic [19:0] player_score;
  logic        display_target, play_en, level_up, game_over, game_win;
  logic [3:0]  level;
  logic [19:0] target_score;
  logic [6:0]  time_left;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  level_sequencer #(
    .FRAMES_PER_SEC(60),
    .TARGET_FRAMES (120),
    .ROUND_SECONDS (60),
    .MAX_LEVEL     (10),
    .SCORE_W       (20)
  ) dut (
    .Clk           (clk),
    .reset         (rst_n),
    .start         (start),
    .frame_start   (frame_start),
    .player_score  (player_score),
    .display_target(display_target),
    .play_en       (play_en),
    .level         (level),
    .target_score  (target_score),
    .time_left     (time_left),
    .level_up      (level_up),
    .game_over     (game_over),
    .game_win      (game_win)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; frame_start = 1'b1; player_score = '0;
    tick(); tick();
    start = 1'b0; frame_start = 1'b0;
    n_checks++; if ({display_target, play_en, level_up, game_over, game_win} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {display_target, play_en, level_up, game_over, game_win}); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (target_score !== 20'd0) begin n_fail++; $display("FAIL reset_target: got %0d expected 0", target_score); end
    n_checks++; if (time_left !== 7'd0) begin n_fail++; $display("FAIL reset_time: got %0d expected 0", time_left); end
    rst_n = 1'b1;
    frames(3, 1'b0);
    n_checks++; if (display_target !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_frame: got %b expected 0", display_target); end
  endtask

  task automatic test_start_target();
    start = 1'b1; frame_start = 1'b1;
    tick();
    start = 1'b0; frame_start = 1'b0;
    n_checks++; if (display_target !== 1'b1) begin n_fail++; $display("FAIL start_display: got %b expected 1", display_target); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL start_level: got %0d expected 1", level); end
    n_checks++; if (target_score !== 20'd80) begin n_fail++; $display("FAIL start_target: got %0d expected 80", target_score); end
    frames(119, 1'b0);
    n_checks++; if ({display_target, play_en} !== 2'b10) begin n_fail++; $display("FAIL target_119: got %b expected 10", {display_target, play_en}); end
    pulse_start();
    n_checks++; if ({display_target, level} !== 5'b1_0001) begin n_fail++; $display("FAIL start_in_target: got %b expected 10001", {display_target, level}); end
    frames(1, 1'b0);
    n_checks++; if ({display_target, play_en} !== 2'b01) begin n_fail++; $display("FAIL target_to_play: got %b expected 01", {display_target, play_en}); end
    n_checks++; if (time_left !== 7'd60) begin n_fail++; $display("FAIL play_load_time: got %0d expected 60", time_left); end
  endtask

  task automatic test_countdown_level_up();
    frames(59, 1'b1);
    n_checks++; if (time_left !== 7'd60) begin n_fail++; $display("FAIL time_59_frames: got %0d expected 60", time_left); end
    frames(1, 1'b1);
    n_checks++; if (time_left !== 7'd59) begin n_fail++; $display("FAIL time_60_frames: got %0d expected 59", time_left); end
    frames(3539, 1'b0);
    n_checks++; if ({play_en, time_left} !== {1'b1, 7'd1}) begin n_fail++; $display("FAIL time_last_sec: got %0d/%0d expected 1/1", play_en, time_left); end
    pulse_start();
    n_checks++; if ({play_en, level, time_left} !== {1'b1, 4'd1, 7'd1}) begin n_fail++; $display("FAIL start_in_play: got %0d/%0d/%0d expected 1/1/1", play_en, level, time_left); end
    frames(1, 1'b0);
    n_checks++; if ({display_target, play_en, level_up, time_left} !== {3'b000, 7'd0}) begin
      n_fail++; $display("FAIL enter_check: got %b/%0d expected 000/0", {display_target, play_en, level_up}, time_left); end
    player_score = 20'd80;
    tick();
    player_score = '0;
    n_checks++; if ({level_up, display_target, level} !== {2'b11, 4'd2}) begin n_fail++; $display("FAIL level_up_l1: got %b/%0d expected 11/2", {level_up, display_target}, level); end
    n_checks++; if (target_score !== 20'd320) begin n_fail++; $display("FAIL target_l2: got %0d expected 320", target_score); end
    tick();
    n_checks++; if (level_up !== 1'b0) begin n_fail++; $display("FAIL level_up_width: got %b expected 0", level_up); end
  endtask

  task automatic test_lose_restart();
    frames(3720, 1'b0);
    player_score = 20'd319;
    tick();
    player_score = '0;
    n_checks++; if ({game_over, level_up, display_target, level} !== {3'b100, 4'd2}) begin
      n_fail++; $display("FAIL lose_l2: got %b/%0d expected 100/2", {game_over, level_up, display_target}, level); end
    frames(3, 1'b0);
    n_checks++; if ({game_over, time_left} !== {1'b1, 7'd0}) begin n_fail++; $display("FAIL lose_ignores_frame: got %0d/%0d expected 1/0", game_over, time_left); end
    pulse_start();
    n_checks++; if ({game_over, display_target, level} !== {2'b01, 4'd1}) begin n_fail++; $display("FAIL restart_after_lose: got %b/%0d expected 01/1", {game_over, display_target}, level); end
    n_checks++; if (target_score !== 20'd80) begin n_fail++; $display("FAIL restart_target: got %0d expected 80", target_score); end
    frames(3720, 1'b0);
    player_score = 20'd79;
    tick();
    player_score = '0;
    n_checks++; if ({game_over, level} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL lose_l1_79: got %0d/%0d expected 1/1", game_over, level); end
  endtask

  task automatic test_reset_mid_play();
    pulse_start();
    frames(120 + 1800, 1'b0);
    n_checks++; if ({play_en, time_left} !== {1'b1, 7'd30}) begin n_fail++; $display("FAIL mid_play_time: got %0d/%0d expected 1/30", play_en, time_left); end
    rst_n = 1'b0; frame_start = 1'b1;
    tick();
    rst_n = 1'b1; frame_start = 1'b0;
    n_checks++; if ({display_target, play_en, level_up, game_over, game_win, level, time_left} !== 16'd0) begin
      n_fail++; $display("FAIL mid_play_reset: got %b/%0d/%0d expected 00000/0/0", {display_target, play_en, level_up, game_over, game_win}, level, time_left); end
    n_checks++; if (target_score !== 20'd0) begin n_fail++; $display("FAIL mid_play_reset_target: got %0d expected 0", target_score); end
  endtask

  task automatic test_win();
    int exp_t;
    pulse_start();
    for (int l = 1; l <= 10; l++) begin
      frames(3720, 1'b0);
      player_score = 20'(80 * l * l);
      tick();
      player_score = '0;
      if (l < 10) begin
        exp_t = 80 * (l + 1) * (l + 1);
        n_checks++; if ({level_up, level, target_score} !== {1'b1, 4'(l + 1), 20'(exp_t)}) begin
          n_fail++; $display("FAIL win_run_l%0d: got %0d/%0d/%0d expected 1/%0d/%0d", l, level_up, level, target_score, l + 1, exp_t); end
      end else begin
        n_checks++; if ({game_win, level_up, display_target, game_over, level} !== {4'b1000, 4'd10}) begin
          n_fail++; $display("FAIL win_l10: got %b/%0d expected 1000/10", {game_win, level_up, display_target, game_over}, level); end
      end
    end
    pulse_start();
    n_checks++; if ({game_win, display_target, level} !== {2'b01, 4'd1}) begin n_fail++; $display("FAIL restart_after_win: got %b/%0d expected 01/1", {game_win, display_target}, level); end
  endtask

`ifdef LEVEL_SEQ_EARLY_EXIT_EN
  task automatic test_early_exit();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pulse_start();
    frames(120 + 1080, 1'b0);
    n_checks++; if (time_left !== 7'd42) begin n_fail++; $display("FAIL early_time: got %0d expected 42", time_left); end
    player_score = 20'd80;
    frames(1, 1'b0);
    n_checks++; if ({play_en, time_left} !== {1'b0, 7'd42}) begin n_fail++; $display("FAIL early_check: got %0d/%0d expected 0/42", play_en, time_left); end
    tick();
    player_score = '0;
    n_checks++; if ({level_up, level, time_left} !== {1'b1, 4'd2, 7'd42}) begin n_fail++; $display("FAIL early_level_up: got %0d/%0d/%0d expected 1/2/42", level_up, level, time_left); end
    frames(120, 1'b0);
    n_checks++; if ({play_en, time_left} !== {1'b1, 7'd60}) begin n_fail++; $display("FAIL early_reload: got %0d/%0d expected 1/60", play_en, time_left); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_start = 1'b0; player_score = '0;
    test_reset();
    test_start_target();
    test_countdown_level_up();
    test_lose_restart();
    test_reset_mid_play();
    test_win();
`ifdef LEVEL_SEQ_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
